// File: rtl/paraleloserial_pkg.sv
// Shared constants for the parallel-to-serial transmitter.
// K28.5 constants are used only when COMMA_IDLE_EN is defined.
package paraleloserial_pkg;

    // Default parallel word width, which is also the slot length in clocks
    localparam int unsigned WIDTH_DEFAULT = 10;

    // K28.5 code groups, stored with transmission bit a at index 0
    // RD-: a..j = 0011111010    RD+: a..j = 1100000101
    localparam logic [9:0] K28_5_RDN = 10'b0101111100;
    localparam logic [9:0] K28_5_RDP = 10'b1010000011;

    // Counter width able to hold 0..width-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/contador_bits.sv
// Slot bit counter: counts 0..WIDTH-1 and wraps; wrap is high on the last bit.
module contador_bits
    import paraleloserial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned CW    = cnt_width(WIDTH)
) (
    input  logic          CLOCK,
    input  logic          RESET,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign cnt  = cnt_q;
    assign wrap = (cnt_q == CW'(WIDTH - 1));

    // Next count, returning to zero after the last bit of a slot
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (wrap) begin
            cnt_d = '0;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: one-word holding register feeding a shift
// register that emits one WIDTH-clock slot per word, LSB first. Empty slots
// carry an idle word: all zeros by default, or alternating-disparity K28.5
// commas when COMMA_IDLE_EN is defined.
module paralelo_serial
    import paraleloserial_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] D,
    input  logic             VALID,
    output logic             READY,
    output logic             SOUT,
    output logic             LOADS,
    output logic             IDLE
);

    localparam int unsigned CW = cnt_width(WIDTH);

`ifdef COMMA_IDLE_EN
    localparam logic [WIDTH-1:0] IDLE_RDN   = WIDTH'(K28_5_RDN);
    localparam logic [WIDTH-1:0] IDLE_RDP   = WIDTH'(K28_5_RDP);
    localparam logic [WIDTH-1:0] IDLE_RESET = IDLE_RDN;
`else
    localparam logic [WIDTH-1:0] IDLE_RESET = '0;
`endif

    logic [CW-1:0]    cnt;
    logic             wrap;
    logic [WIDTH-1:0] idle_word;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             hold_full_q, hold_full_d;
    logic             ready_q, ready_d;
    logic             idle_q, idle_d;
    logic             accept;

    contador_bits #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_contador (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .cnt   (cnt),
        .wrap  (wrap)
    );

`ifdef COMMA_IDLE_EN
    logic rd_q, rd_d;  // 0 = RD-, 1 = RD+

    // Disparity flips at the end of every comma slot; data slots leave it alone
    always_comb begin
        rd_d = rd_q;
        if (wrap && idle_q) begin
            rd_d = ~rd_q;
        end
        idle_word = rd_d ? IDLE_RDP : IDLE_RDN;
    end

    // Running disparity register; reset state matches the RD- comma in shift
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
        end
    end
`else
    assign idle_word = '0;
`endif

    // Hold/shift next state: slot load on wrap, word capture on handshake
    always_comb begin
        accept      = VALID && ready_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q >> 1;
        idle_d      = idle_q;
        if (wrap) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                idle_d      = 1'b0;
                hold_full_d = 1'b0;
            end else begin
                shift_d = idle_word;
                idle_d  = 1'b1;
            end
        end
        // A word accepted on the wrap edge itself waits for the next slot
        if (accept) begin
            hold_d      = D;
            hold_full_d = 1'b1;
        end
        // Drops on the accepting edge; rises one clock after the hold empties
        ready_d = !hold_full_q && !accept;
    end

    // State registers; reset drops any held word and restarts on an idle slot
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b0;
            shift_q     <= IDLE_RESET;
            idle_q      <= 1'b1;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            shift_q     <= shift_d;
            idle_q      <= idle_d;
        end
    end

    assign READY = ready_q;
    assign SOUT  = shift_q[0];
    assign IDLE  = idle_q;
    assign LOADS = (cnt == '0) && !idle_q;

endmodule

// File: doc/paralelo_serial.md
PARALELO_SERIAL -- requirements
Module: paralelo_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 10, the parallel word width in bits and the serial slot length in clocks.
REQ-002 SHALL have port CLOCK  input  1  the single clock; all state updates on posedge CLOCK.
REQ-003 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port D  input  WIDTH  the parallel word from the upstream generator; D[0] is transmitted first.
REQ-005 SHALL have port VALID  input  1  high when D holds a word to send.
REQ-006 SHALL have port READY  output  1  high when the holding register is empty.
REQ-007 SHALL have port SOUT  output  1  the serial bit stream, one bit per clock.
REQ-008 SHALL have port LOADS  output  1  a one-clock pulse on the first bit of each data slot.
REQ-009 SHALL have port IDLE  output  1  high for every clock of a slot carrying the idle pattern.

Function
REQ-010 SHALL use a bit counter cnt that counts 0..WIDTH-1 and wraps to 0; each cnt cycle is one slot.
REQ-011 SHALL accept a word when VALID and READY are both high at a posedge; D is then captured into the holding register and hold_full is set.
REQ-012 SHALL drive READY = !hold_full as a registered value.
REQ-013 SHALL, at the posedge where cnt==WIDTH-1, load the shift register from the holding register if hold_full is set (and clear hold_full), and otherwise load it with the idle word.
REQ-014 SHALL drive SOUT = shift[0] and shift right by one each clock inside a slot, so bit k of the loaded word appears at SOUT when cnt==k.
REQ-015 SHALL ignore VALID while READY is low; D need not be held stable once accepted.
REQ-016 SHALL, when hold_full is set and cnt==WIDTH-1 in the same cycle, transfer the word and raise READY on the next clock; no word is lost or duplicated.
REQ-017 SHALL give a latency from acceptance to the first bit at SOUT equal to the remaining cycles until the cnt==WIDTH-1 edge plus 1; the maximum is WIDTH+1 clocks.
REQ-018 SHALL assert LOADS while cnt==0 only for data slots, and assert IDLE for all WIDTH clocks of idle slots.
REQ-019 SHALL sustain back-to-back slots without gaps when VALID is held high, giving one word per WIDTH clocks.

Reset
REQ-020 SHALL, while RESET is high, set cnt=0, hold_full=0, READY=0, LOADS=0, IDLE=1, RD=negative, and shift=idle word.
REQ-021 SHALL, on the first clock after RESET deasserts, set READY=1 and emit idle-word bit 0 at SOUT.
REQ-022 SHALL, if RESET is asserted mid-slot, discard both the partial slot and any held word.

Configuration
REQ-023 SHALL, with COMMA_IDLE_EN defined, use K28.5 as the idle word: RD- is a..j=0011111010 and RD+ is a..j=1100000101, with D[0]=a.
REQ-024 SHALL, with COMMA_IDLE_EN defined, toggle RD after every comma sent; data slots do not change RD.
REQ-025 SHALL, without COMMA_IDLE_EN, use an all-zero idle word and SHALL NOT contain an RD register.

Structure
REQ-026 SHALL place WIDTH default, K28_5_RDN and K28_5_RDP constants in shared package paraleloserial_pkg.
REQ-027 SHALL implement the slot counter as sub-module contador_bits, which outputs cnt and a wrap pulse at cnt==WIDTH-1.

Verification
REQ-028 SHALL cover this scenario: RESET for 3 clocks, then release with VALID=0 -> with COMMA_IDLE_EN, SOUT carries 0011111010 then 1100000101 alternately, IDLE=1 and LOADS=0.
REQ-029 SHALL cover this scenario: a single word D=10'b1010110001 accepted at cnt==3 -> SOUT carries 1,0,0,0,1,1,0,1,0,1 in the next slot, LOADS pulses once and READY is low for 7 clocks.
REQ-030 SHALL cover this scenario: VALID held high with D incrementing 0..5 -> six consecutive data slots over 60 clocks with no idle slot between them.
REQ-031 SHALL cover this scenario: acceptance on the same posedge as cnt==9 while hold is empty -> the next slot is idle and the word follows in the slot after it.
REQ-032 SHALL cover this scenario: RESET asserted at cnt==5 of a data slot with hold_full=1 -> the next slot after release is idle, nothing held is sent, and READY=1.
REQ-033 SHALL cover this scenario: the build without COMMA_IDLE_EN and idle stimulus -> SOUT=0 constantly and IDLE=1.
